// File: rtl/banco_segmentado_pkg.sv
// Shared constants for the two-stage R-type register bank: default widths,
// instruction field positions and the supported funct codes.
package banco_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   localparam int INSTR_W   = 32;
   localparam int FIELD_W   = 5;
   localparam int FUNCT_W   = 6;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int FUNCT_LSB = 0;

   localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'h00;
   localparam logic [FUNCT_W-1:0] FUNCT_SRL  = 6'h02;
   localparam logic [FUNCT_W-1:0] FUNCT_SRA  = 6'h03;
   localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'h20;
   localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'h22;
   localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
   localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
   localparam logic [FUNCT_W-1:0] FUNCT_XOR  = 6'h26;
   localparam logic [FUNCT_W-1:0] FUNCT_NOR  = 6'h27;
   localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'h2A;
   localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 6'h2B;

   function automatic logic [FIELD_W-1:0] campo(input logic [INSTR_W-1:0] palabra,
                                                input int lsb);
      campo = palabra[lsb +: FIELD_W];
   endfunction

endpackage

// File: rtl/banco_segmentado_alu.sv
// Combinational R-type ALU; a is the rs operand, b the rt operand.
// Shifts move b by the low log2(DATA_W) bits of a.
module alu_param
   import banco_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   input  logic [FUNCT_W-1:0] funct,
   output logic [DATA_W-1:0]  resultado,
   output logic               illegal
);

   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] sh_s;

   assign sh_s = a[SH_W-1:0];

   // funct decode and result selection; unknown codes yield 0 and flag illegal
   always_comb begin
      resultado = '0;
      illegal   = 1'b0;
      case (funct)
         FUNCT_ADD:  resultado = a + b;
         FUNCT_SUB:  resultado = a - b;
         FUNCT_AND:  resultado = a & b;
         FUNCT_OR:   resultado = a | b;
         FUNCT_XOR:  resultado = a ^ b;
         FUNCT_NOR:  resultado = ~(a | b);
         FUNCT_SLT:  resultado = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         FUNCT_SLTU: resultado = {{(DATA_W-1){1'b0}}, (a < b)};
         FUNCT_SLL:  resultado = b << sh_s;
         FUNCT_SRL:  resultado = b >> sh_s;
         FUNCT_SRA:  resultado = $unsigned($signed(b) >>> sh_s);
         default: begin
            resultado = '0;
            illegal   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/banco_segmentado.sv
// Two-stage register bank: S1 holds decoded fields, S2 holds the ALU result
// that is written back when the consumer accepts it.
module banco_segmentado
   import banco_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [31:0]        instruccion,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [DATA_W-1:0]  res_data,
   output logic [ADDR_W-1:0]  res_rd,
   output logic               res_illegal,
   input  logic [ADDR_W-1:0]  dbg_addr,
   output logic [DATA_W-1:0]  dbg_data
);

   localparam int NREGS = 2**ADDR_W;

   logic [FIELD_W-1:0] rs_field_s, rt_field_s, rd_field_s;
   logic [FUNCT_W-1:0] funct_field_s;
   logic               unused_bits_s;

   logic               s1_valid_q, s1_valid_d;
   logic [ADDR_W-1:0]  s1_rs_q, s1_rs_d;
   logic [ADDR_W-1:0]  s1_rt_q, s1_rt_d;
   logic [ADDR_W-1:0]  s1_rd_q, s1_rd_d;
   logic [FUNCT_W-1:0] s1_funct_q, s1_funct_d;

   logic               res_valid_q, res_valid_d;
   logic [DATA_W-1:0]  res_data_q, res_data_d;
   logic [ADDR_W-1:0]  res_rd_q, res_rd_d;
   logic               res_illegal_q, res_illegal_d;

   logic [DATA_W-1:0]  regs_q [NREGS];
   logic [DATA_W-1:0]  regs_d [NREGS];

   logic               advance_s, accept_s, wb_s, fwd_ok_s;
   logic [DATA_W-1:0]  op_a_s, op_b_s, alu_res_s;
   logic               alu_ill_s;

   assign rs_field_s    = campo(instruccion, RS_LSB);
   assign rt_field_s    = campo(instruccion, RT_LSB);
   assign rd_field_s    = campo(instruccion, RD_LSB);
   assign funct_field_s = instruccion[FUNCT_LSB +: FUNCT_W];
   assign unused_bits_s = ^{instruccion[INSTR_W-1:RS_LSB+FIELD_W],
                            instruccion[RD_LSB-1:FUNCT_LSB+FUNCT_W],
                            rs_field_s, rt_field_s, rd_field_s};

   assign advance_s   = !res_valid_q || res_ready;
   assign instr_ready = !s1_valid_q || advance_s;
   assign accept_s    = instr_valid && instr_ready;
   assign wb_s        = res_valid_q && res_ready && !res_illegal_q && (res_rd_q != '0);
   // S2 may feed S1 even when it retires this very edge: its write is not yet visible.
   assign fwd_ok_s    = res_valid_q && !res_illegal_q && (res_rd_q != '0);

   // operand fetch with bypass from S2 and hard-wired zero register
   always_comb begin
      op_a_s = '0;
      op_b_s = '0;
      if (fwd_ok_s && (res_rd_q == s1_rs_q)) begin
         op_a_s = res_data_q;
      end else if (s1_rs_q == '0) begin
         op_a_s = '0;
      end else begin
         op_a_s = regs_q[s1_rs_q];
      end
      if (fwd_ok_s && (res_rd_q == s1_rt_q)) begin
         op_b_s = res_data_q;
      end else if (s1_rt_q == '0) begin
         op_b_s = '0;
      end else begin
         op_b_s = regs_q[s1_rt_q];
      end
   end

   alu_param #(.DATA_W(DATA_W)) u_alu (
      .a         (op_a_s),
      .b         (op_b_s),
      .funct     (s1_funct_q),
      .resultado (alu_res_s),
      .illegal   (alu_ill_s)
   );

   // S1 next state: load on accept, empty when it drains into S2, else hold
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_rs_d    = s1_rs_q;
      s1_rt_d    = s1_rt_q;
      s1_rd_d    = s1_rd_q;
      s1_funct_d = s1_funct_q;
      if (accept_s) begin
         s1_valid_d = 1'b1;
         s1_rs_d    = rs_field_s[ADDR_W-1:0];
         s1_rt_d    = rt_field_s[ADDR_W-1:0];
         s1_rd_d    = rd_field_s[ADDR_W-1:0];
         s1_funct_d = funct_field_s;
      end else if (advance_s) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // S2 next state: capture the ALU result when the stage can advance
   always_comb begin
      res_valid_d   = res_valid_q;
      res_data_d    = res_data_q;
      res_rd_d      = res_rd_q;
      res_illegal_d = res_illegal_q;
      if (advance_s) begin
         res_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            res_data_d    = alu_res_s;
            res_rd_d      = s1_rd_q;
            res_illegal_d = alu_ill_s;
         end else begin
            res_data_d    = res_data_q;
            res_rd_d      = res_rd_q;
            res_illegal_d = res_illegal_q;
         end
      end else begin
         res_valid_d = res_valid_q;
      end
   end

   // register file write port; entry 0 is never written
   always_comb begin
      regs_d[0] = '0;
      for (int i = 1; i < NREGS; i++) begin
         regs_d[i] = (wb_s && (res_rd_q == ADDR_W'(i))) ? res_data_q : regs_q[i];
      end
   end

   // pipeline registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q    <= 1'b0;
         s1_rs_q       <= '0;
         s1_rt_q       <= '0;
         s1_rd_q       <= '0;
         s1_funct_q    <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_rd_q      <= '0;
         res_illegal_q <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_rs_q       <= s1_rs_d;
         s1_rt_q       <= s1_rt_d;
         s1_rd_q       <= s1_rd_d;
         s1_funct_q    <= s1_funct_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_rd_q      <= res_rd_d;
         res_illegal_q <= res_illegal_d;
      end
   end

   // register file storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_rd      = res_rd_q;
   assign res_illegal = res_illegal_q;
   assign dbg_data    = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: doc/banco_segmentado.md
BANCO_SEGMENTADO -- requirements
Module: banco_segmentado

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the registers and datapath.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the register-address width, giving 2**ADDR_W registers.
REQ-003 SHALL have these ports, one per line (name, direction, width, meaning); clock and reset are listed first:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruccion is offered this cycle.
- instr_ready  output  1  block accepts instruccion this cycle.
- instruccion  input  32  R-type word: [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct (uses the low ADDR_W bits of each address field).
- res_valid  output  1  res_data, res_rd and res_illegal are valid.
- res_ready  input  1  consumer accepts the result.
- res_data  output  DATA_W  ALU result.
- res_rd  output  ADDR_W  destination register.
- res_illegal  output  1  funct was not a supported code.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  combinational register-file read of dbg_addr.

Function
REQ-004 SHALL be a two-stage pipeline: S1 holds the decoded fields; S2 holds the computed result; throughput is one instruction per cycle when res_ready=1.
REQ-005 SHALL accept an instruction on a rising edge where instr_valid=1 and instr_ready=1; instr_ready = !s1_valid || advance, where advance = !res_valid || res_ready.
REQ-006 SHALL read the operands and compute in the cycle where S1 moves to S2, so res_valid rises two edges after acceptance.
REQ-007 SHALL forward: if S2 is valid, not illegal, res_rd≠0 and res_rd equals rs or rt of the S1 entry, that operand takes res_data instead of the register-file value.
REQ-008 SHALL write res_data into register res_rd on an edge where res_valid=1 and res_ready=1, unless res_rd=0 or res_illegal=1.
REQ-009 SHALL read register 0 as 0 always, including via dbg_data.
REQ-010 SHALL support these funct codes: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT (signed, result 1/0), 0x2B SLTU, 0x00 SLL rt by rs[log2 DATA_W-1:0], 0x02 SRL, 0x03 SRA.
REQ-011 SHALL wrap ADD/SUB modulo 2**DATA_W with no overflow flag.
REQ-012 SHALL, for any other funct, pass res_valid with res_illegal=1 and res_data=0, with no register write.
REQ-013 SHALL hold the S2 outputs stable while res_valid=1 and res_ready=0; S1 holds, and instr_ready=0 if S1 is full.
REQ-014 SHALL let a write-back and a new S1→S2 transfer occur on the same edge; that transfer uses the forwarded value (REQ-007).
REQ-015 SHALL deassert res_valid after an accepted result if no S1 entry is moving in.

Reset
REQ-016 SHALL, while reset=1, clear s1_valid and res_valid to 0, res_data/res_rd/res_illegal to 0, and every register to 0, asynchronously.
REQ-017 SHALL discard in-flight instructions on reset, with no write-back; instr_ready=1 on the first cycle after reset is released.

Structure
REQ-018 SHALL put the funct constants, the field bit positions and the default widths in package banco_pkg.
REQ-019 SHALL implement the ALU as the combinational sub-module alu_param #(DATA_W), with inputs a, b, funct and outputs resultado, illegal.
REQ-020 SHALL implement the register file as a flop array inside banco_segmentado with two combinational read ports, one debug read port and one write port.

Verification
REQ-021 SHALL cover RAW back-to-back: ADD r3=r1+r2 then ADD r4=r3+r3, with r1=5 and r2=7 set via earlier instructions; the results are 12 then 24, at one per cycle.
REQ-022 SHALL cover backpressure: res_ready=0 for 3 cycles with 3 instructions issued; instr_ready drops after 2 accepted, res_data is held, and all 3 results follow in order once res_ready=1.
REQ-023 SHALL cover the zero register: OR r0=r1|r2 with r1=0xF0; res_data=0xF0, and afterwards dbg_addr=0 gives 0 and a later rs=0 reads 0.
REQ-024 SHALL cover illegal funct: funct 0x3F; res_illegal=1, res_data=0, and rd is unchanged.
REQ-025 SHALL cover arithmetic edges: 0x7FFFFFFF+1 gives 0x80000000; SLT -1<1 gives 1; SLTU 0xFFFFFFFF<1 gives 0; SRA 0x80000000 by 4 gives 0xF8000000.
REQ-026 SHALL cover reset mid-flight: reset asserted with S1 and S2 full; res_valid=0 immediately, every register reads 0, and the next instruction completes normally.
